// File: rtl/jellyvl_etherneco_synctimer_delay_writer.sv
// Inner-ring stream stage: passes bytes through with one cycle latency and writes this node's
// delay record in synctimer response frames. Optional: JELLYVL_ETHERNECO_SYNCTIMER_DELAY_WRITER_HOPCOUNT_EN.
module jellyvl_etherneco_synctimer_delay_writer #(
  parameter logic [7:0]  CMD_ID        = 8'h10,
  parameter int unsigned RECORD_OFFSET = 4
) (
  input  logic        reset,
  input  logic        clk,
  input  logic [7:0]  node_id,
  input  logic [31:0] delay_time,
  input  logic        delay_valid,
  input  logic        s_first,
  input  logic        s_last,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        m_first,
  output logic        m_last,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        write_done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BYPASS = 2'd2
  } state_t;

  localparam logic [10:0] REC_OFS = 11'(RECORD_OFFSET);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  function automatic logic [7:0] delay_byte(input logic [31:0] d, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      2'd3:    b = d[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

`ifdef JELLYVL_ETHERNECO_SYNCTIMER_DELAY_WRITER_HOPCOUNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction
`endif

  state_t      state_r, state_next_s;
  logic [31:0] held_delay_r;
  logic [31:0] frame_delay_r, frame_delay_next_s;
  logic [10:0] target_r, target_next_s;
  logic [15:0] byte_cnt_r, byte_cnt_next_s;
  logic [31:0] snap_delay_s;
  logic [15:0] target_ext_s;
  logic [15:0] rel_s;
  logic        in_record_s;
  logic        hop_s;
  logic [7:0]  data_s;
  logic        write_s;

  // A strobe on the first beat must reach that frame's snapshot.
  assign snap_delay_s = delay_valid ? delay_time : held_delay_r;
  assign target_ext_s = {5'd0, target_r};
  assign rel_s        = byte_cnt_r - target_ext_s;
  assign in_record_s  = (byte_cnt_r >= target_ext_s) && (rel_s < 16'd4);

`ifdef JELLYVL_ETHERNECO_SYNCTIMER_DELAY_WRITER_HOPCOUNT_EN
  assign hop_s = (byte_cnt_r == 16'd1);
`else
  assign hop_s = 1'b0;
`endif

  // Next-state, frame snapshot and data substitution.
  always_comb begin
    state_next_s       = state_r;
    frame_delay_next_s = frame_delay_r;
    target_next_s      = target_r;
    byte_cnt_next_s    = byte_cnt_r;
    data_s             = s_data;
    write_s            = 1'b0;
    if (s_valid) begin
      if (s_first) begin
        frame_delay_next_s = snap_delay_s;
        target_next_s      = REC_OFS + {1'b0, node_id, 2'b00};
        byte_cnt_next_s    = 16'd1;
        if (s_last) begin
          state_next_s = ST_IDLE;
        end else if (s_data == CMD_ID) begin
          state_next_s = ST_ACTIVE;
        end else begin
          state_next_s = ST_BYPASS;
        end
      end else begin
        byte_cnt_next_s = sat_inc16(byte_cnt_r);
        case (state_r)
          ST_ACTIVE: begin
            if (in_record_s) begin
              data_s  = delay_byte(frame_delay_r, rel_s[1:0]);
              write_s = (rel_s[1:0] == 2'd3);
`ifdef JELLYVL_ETHERNECO_SYNCTIMER_DELAY_WRITER_HOPCOUNT_EN
            end else if (hop_s) begin
              data_s = sat_inc8(s_data);
`endif
            end else begin
              data_s = s_data;
            end
            state_next_s = s_last ? ST_IDLE : ST_ACTIVE;
          end
          ST_BYPASS: begin
            state_next_s = s_last ? ST_IDLE : ST_BYPASS;
          end
          default: begin
            state_next_s = ST_IDLE;
          end
        endcase
      end
    end else begin
      state_next_s    = state_r;
      byte_cnt_next_s = byte_cnt_r;
    end
  end

  // Delay latch, frame context and state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      held_delay_r  <= 32'hFFFF_FFFF;
      frame_delay_r <= 32'hFFFF_FFFF;
      target_r      <= 11'd0;
      byte_cnt_r    <= 16'd0;
    end else begin
      state_r       <= state_next_s;
      frame_delay_r <= frame_delay_next_s;
      target_r      <= target_next_s;
      byte_cnt_r    <= byte_cnt_next_s;
      if (delay_valid) begin
        held_delay_r <= delay_time;
      end
    end
  end

  // Output stage; sideband holds its last value across invalid cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_first    <= 1'b0;
      m_last     <= 1'b0;
      m_data     <= 8'h00;
      m_valid    <= 1'b0;
      write_done <= 1'b0;
    end else begin
      m_valid    <= s_valid;
      write_done <= write_s;
      if (s_valid) begin
        m_first <= s_first;
        m_last  <= s_last;
        m_data  <= data_s;
      end
    end
  end

endmodule
